// File: rtl/l1a_bcnt_decoder.sv
// L1A / bCnt strobe decoder: rebuilds {evId, bcid} records and queues them.
// Optional L1A_DEC_SEQCHK_EN adds a seq_err check on consecutive event IDs.
module l1a_bcnt_decoder #(
    parameter int FIFO_AW = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               l1a,
    input  logic [11:0]        bCnt,
    input  logic               bCntStr,
    input  logic               evCntLStr,
    input  logic               evCntHStr,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [11:0]        ev_bcid,
    output logic [23:0]        ev_id,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               proto_err,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   drop_cnt
`ifdef L1A_DEC_SEQCHK_EN
   ,output logic               seq_err
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, GOT_BC, GOT_EVL} state_t;

    state_t              state_q, state_d;
    logic [11:0]         bcid_q, bcid_d;
    logic [11:0]         evl_q, evl_d;
    logic [35:0]         mem_q [DEPTH];
    logic [35:0]         head;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    level_q, level_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                multi, mism, start;
    logic                err, wr_en, full, push, pop, drop;

    // Strobe sanity terms: several strobes at once, l1a without bCntStr
    always_comb begin
        multi = (bCntStr & evCntLStr) | (bCntStr & evCntHStr)
              | (evCntLStr & evCntHStr);
        mism  = l1a ^ bCntStr;
        start = bCntStr & l1a;
    end

    // Record assembly FSM; a start strobe in any error cycle resyncs
    always_comb begin
        state_d = IDLE;
        bcid_d  = bcid_q;
        evl_d   = evl_q;
        err     = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                err = evCntLStr | evCntHStr | mism;
            end
            GOT_BC: begin
                if (evCntLStr & ~multi & ~mism) begin
                    evl_d   = bCnt;
                    state_d = GOT_EVL;
                end else begin
                    err = 1'b1;
                end
            end
            GOT_EVL: begin
                if (evCntHStr & ~multi & ~mism) begin
                    wr_en = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            default: begin
                err = 1'b0;
            end
        endcase
        if (start) begin
            bcid_d  = bCnt;
            state_d = GOT_BC;
        end
    end

    assign full      = (level_q == FULL_LVL);
    assign ev_valid  = (level_q != '0);
    assign pop       = ev_valid & ev_ready;
    assign push      = wr_en & (~full | pop);
    assign drop      = wr_en & full & ~pop;
    assign head      = mem_q[rd_ptr_q];
    assign ev_bcid   = ev_valid ? head[11:0] : '0;
    assign ev_id     = ev_valid ? head[35:12] : '0;
    assign fifo_level = level_q;
    assign proto_err = err & rst_n;
    assign err_cnt   = err_cnt_q;
    assign drop_cnt  = drop_cnt_q;

    // FIFO pointers, fill level and saturating counters
    always_comb begin
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        level_d    = level_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
            default: level_d = level_q;
        endcase
        if (err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (drop && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Control state; reset drops any partial record and empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bcid_q     <= '0;
            evl_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bcid_q     <= bcid_d;
            evl_q      <= evl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage; contents are don't-care until the level covers them
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bCnt, evl_q, bcid_q};
        end
    end

`ifdef L1A_DEC_SEQCHK_EN
    logic [23:0] prev_id_q, prev_id_d;
    logic        have_prev_q, have_prev_d;
    logic [23:0] cur_id;

    assign cur_id  = {bCnt, evl_q};
    assign seq_err = rst_n & wr_en & have_prev_q
                   & (cur_id != prev_id_q + 24'd1);

    // Remember the last completed ID, dropped records included
    always_comb begin
        prev_id_d   = prev_id_q;
        have_prev_d = have_prev_q;
        if (wr_en) begin
            prev_id_d   = cur_id;
            have_prev_d = 1'b1;
        end
    end

    // Sequence-check history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_id_q   <= '0;
            have_prev_q <= 1'b0;
        end else begin
            prev_id_q   <= prev_id_d;
            have_prev_q <= have_prev_d;
        end
    end
`endif

endmodule

// File: tb/tb_l1a_bcnt_decoder.sv
// Bench for l1a_bcnt_decoder: directed cases plus random traffic
// against a queue-based record model.
module tb_l1a_bcnt_decoder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l1a = 1'b0;
    logic [11:0] bCnt = '0;
    logic        bCntStr = 1'b0;
    logic        evCntLStr = 1'b0;
    logic        evCntHStr = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [11:0] ev_bcid;
    logic [23:0] ev_id;
    logic [3:0]  fifo_level;
    logic        proto_err;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
`ifdef L1A_DEC_SEQCHK_EN
    logic        seq_err;
`endif

    l1a_bcnt_decoder #(.FIFO_AW(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .l1a(l1a), .bCnt(bCnt),
        .bCntStr(bCntStr), .evCntLStr(evCntLStr), .evCntHStr(evCntHStr),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_bcid(ev_bcid),
        .ev_id(ev_id), .fifo_level(fifo_level), .proto_err(proto_err),
        .err_cnt(err_cnt), .drop_cnt(drop_cnt)
`ifdef L1A_DEC_SEQCHK_EN
       ,.seq_err(seq_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [23:0] id;
        logic [11:0] bc;
    } rec_t;

    logic [11:0] part[$];
    rec_t        q[$];
    int          m_err = 0;
    int          m_drop = 0;
`ifdef L1A_DEC_SEQCHK_EN
    bit          have_prev = 0;
    logic [23:0] prev_id = '0;
`endif

    bit rnd_mode = 0;
    int thr = 9;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic bit is_legal();
        int n = int'(bCntStr) + int'(evCntLStr) + int'(evCntHStr);
        if (n != 1 || l1a != bCntStr) return 1'b0;
        if (part.size() == 0) return bCntStr;
        if (part.size() == 1) return evCntLStr;
        return evCntHStr;
    endfunction

    function automatic bit is_err();
        bit quiet = !bCntStr && !evCntLStr && !evCntHStr && !l1a;
        return !is_legal() && !(part.size() == 0 && quiet);
    endfunction

    function automatic logic [23:0] done_id();
        return {bCnt, part[1]};
    endfunction

    // model state update on each clock edge or reset
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                part.delete();
                q.delete();
                m_err = 0;
                m_drop = 0;
`ifdef L1A_DEC_SEQCHK_EN
                have_prev = 0;
`endif
            end else begin
                bit lg, er, cp, pp;
                rec_t r;
                lg = is_legal();
                er = is_err();
                cp = lg && part.size() == 2;
                pp = (q.size() != 0) && ev_ready;
                if (er && m_err < 255) m_err++;
                r = '0;
                if (cp) begin
                    r.id = done_id();
                    r.bc = part[0];
`ifdef L1A_DEC_SEQCHK_EN
                    have_prev = 1;
                    prev_id = r.id;
`endif
                end
                if (pp) void'(q.pop_front());
                if (cp) begin
                    if (q.size() < DEPTH) q.push_back(r);
                    else if (m_drop < 255) m_drop++;
                end
                if (lg) begin
                    if (cp) part.delete();
                    else part.push_back(bCnt);
                end else begin
                    part.delete();
                    if (bCntStr && l1a) part.push_back(bCnt);
                end
            end
        end
    end

    // compare DUT against the model every cycle
    always @(negedge clk) begin
        bit v;
        v = q.size() != 0;
        chk("ev_valid", ev_valid, v);
        chk("ev_bcid", ev_bcid, v ? q[0].bc : 12'h0);
        chk("ev_id", ev_id, v ? q[0].id : 24'h0);
        chk("fifo_level", fifo_level, q.size());
        chk("proto_err", proto_err, rst_n && is_err());
        chk("err_cnt", err_cnt, m_err);
        chk("drop_cnt", drop_cnt, m_drop);
`ifdef L1A_DEC_SEQCHK_EN
        begin
            bit se;
            se = rst_n && is_legal() && part.size() == 2 && have_prev
                 && (done_id() != prev_id + 24'd1);
            chk("seq_err", seq_err, se);
        end
`endif
    end

    task automatic quiet();
        l1a = 0; bCntStr = 0; evCntLStr = 0; evCntHStr = 0; bCnt = '0;
    endtask

    task automatic drive(input bit a, input bit b, input bit l, input bit h,
                         input logic [11:0] w);
        l1a = a; bCntStr = b; evCntLStr = l; evCntHStr = h; bCnt = w;
        if (rnd_mode) ev_ready = ($urandom_range(0, 9) < thr);
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input logic [11:0] bc, input logic [23:0] id);
        drive(1, 1, 0, 0, bc);
        drive(0, 0, 1, 0, id[11:0]);
        drive(0, 0, 0, 1, id[23:12]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 12'h000);
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic [23:0] evc;
        // reset state
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_errcnt", err_cnt, 0);
        rst_n = 1;
        idle(2);

        // single record and its latency
        ev_ready = 0;
        seq(12'h5FD, 24'h0004C6);
        quiet();
        #1;
        chk("t1_valid", ev_valid, 1);
        chk("t1_bcid", ev_bcid, 12'h5FD);
        chk("t1_id", ev_id, 24'h0004C6);
        chk("t1_level", fifo_level, 1);
        ev_ready = 1;
        idle(3);

        // ten legal records, consumer always ready
        do_reset();
        for (int i = 0; i < 10; i++) begin
            seq(12'h100 + 12'(i), 24'h4C6 + 24'(i));
            idle(9);
        end
        quiet();
        #1;
        chk("t2_errcnt", err_cnt, 0);
        chk("t2_level", fifo_level, 0);

        // lone bCntStr
        drive(1, 1, 0, 0, 12'h123);
        quiet();
        #1;
        chk("t3_perr", proto_err, 1);
        @(posedge clk);
        #1;
        chk("t3_errcnt", err_cnt, 1);
        chk("t3_level", fifo_level, 0);

        // double bCntStr resyncs onto the second BCID
        ev_ready = 0;
        drive(1, 1, 0, 0, 12'h0AA);
        drive(1, 1, 0, 0, 12'h0BB);
        drive(0, 0, 1, 0, 12'h4D0);
        drive(0, 0, 0, 1, 12'h000);
        quiet();
        #1;
        chk("t4_bcid", ev_bcid, 12'h0BB);
        chk("t4_id", ev_id, 24'h0004D0);
        chk("t4_errcnt", err_cnt, 2);
        ev_ready = 1;
        idle(3);

        // overflow: 11 records into 8 slots
        do_reset();
        ev_ready = 0;
        for (int i = 0; i < 11; i++) seq(12'h200 + 12'(i), 24'h500 + 24'(i));
        quiet();
        #1;
        chk("t5_level", fifo_level, 8);
        chk("t5_drop", drop_cnt, 3);
        chk("t5_head", ev_id, 24'h000500);
        ev_ready = 1;
        idle(12);

        // reset in the middle of a record
        ev_ready = 0;
        seq(12'h321, 24'h000777);
        drive(1, 1, 0, 0, 12'h3AB);
        drive(0, 0, 1, 0, 12'h001);
        chk("t6_pre_level", fifo_level, 1);
        quiet();
        rst_n = 0;
        #1;
        chk("t6_valid", ev_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_id", ev_id, 0);
        chk("t6_errcnt", err_cnt, 0);
        chk("t6_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);
        chk("t6_post_level", fifo_level, 0);

`ifdef L1A_DEC_SEQCHK_EN
        // gap in event IDs
        ev_ready = 1;
        seq(12'h010, 24'h0004C6);
        idle(2);
        drive(1, 1, 0, 0, 12'h011);
        drive(0, 0, 1, 0, 12'h4C8);
        evCntLStr = 0;
        evCntHStr = 1;
        bCnt = 12'h000;
        #1;
        chk("t7_seq", seq_err, 1);
        @(posedge clk);
        #1;
        quiet();
        idle(3);
`endif

        // error counter saturation
        do_reset();
        repeat (270) drive(0, 0, 0, 1, 12'h000);
        quiet();
        #1;
        chk("sat_errcnt", err_cnt, 8'hFF);

        // random traffic
        do_reset();
        rnd_mode = 1;
        evc = 24'h000100;
        for (int k = 0; k < 450; k++) begin
            int r;
            thr = ((k / 40) % 2 == 0) ? 9 : 2;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                idle($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) evc = 24'($urandom);
                seq(12'($urandom), evc);
                evc = evc + 24'd1;
            end else if (r < 97) begin
                logic [3:0] s;
                s = 4'($urandom_range(0, 15));
                drive(s[3], s[2], s[1], s[0], 12'($urandom));
            end else begin
                do_reset();
            end
        end
        rnd_mode = 0;
        ev_ready = 1;
        idle(20);
        chk("end_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
